// File: rtl/updown_count_monitor_if.sv
// Bus between the count monitor and whatever drives or observes it.
// The master side presents the sampled counter; the slave side returns the check results.
interface updown_count_monitor_if #(
   parameter int WIDTH   = 3,
   parameter int WRAPS_W = 8
);
   logic               en;
   logic               clr;
   logic               mode;
   logic [WIDTH-1:0]   count_in;
   logic               wrap_up;
   logic               wrap_dn;
   logic               step_err;
   logic               fault;
   logic [WRAPS_W-1:0] wrap_cnt;
   logic [1:0]         state;

   modport master (
      output en, clr, mode, count_in,
      input  wrap_up, wrap_dn, step_err, fault, wrap_cnt, state
   );

   modport slave (
      input  en, clr, mode, count_in,
      output wrap_up, wrap_dn, step_err, fault, wrap_cnt, state
   );
endinterface

// File: rtl/updown_count_monitor.sv
// Checks every enabled transition of an up/down counter for hold/+1/-1 legality,
// reports wraps with a saturating tally, and latches a sticky fault on a bad step.
//
// state  | meaning
// IDLE   | no reference value yet; next enabled sample becomes the reference
// TRACK  | each enabled sample is checked against the previous sample and mode
// FAULT  | an illegal step was seen; only clr or reset leaves this state
module updown_count_monitor #(
   parameter int WIDTH   = 3,
   parameter int WRAPS_W = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   updown_count_monitor_if.slave       bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0]   CNT_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0]   CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WRAPS_W-1:0] WRAP_ONE = WRAPS_W'(1);
   localparam logic [WRAPS_W-1:0] WRAP_MAX = {WRAPS_W{1'b1}};

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   prev_cnt_q, prev_cnt_d;
   logic               prev_mode_q, prev_mode_d;
   logic               wrap_up_q, wrap_up_d;
   logic               wrap_dn_q, wrap_dn_d;
   logic               step_err_q, step_err_d;
   logic               fault_q, fault_d;
   logic [WRAPS_W-1:0] wrap_cnt_q, wrap_cnt_d;
   logic [WIDTH-1:0]   exp_up, exp_dn;
   logic [WRAPS_W-1:0] wrap_cnt_inc;

   assign exp_up       = prev_cnt_q + CNT_ONE;
   assign exp_dn       = prev_cnt_q - CNT_ONE;
   assign wrap_cnt_inc = (wrap_cnt_q == WRAP_MAX) ? wrap_cnt_q : wrap_cnt_q + WRAP_ONE;

   always_ff @(posedge clk) begin
      if (!reset || bus.clr) begin
         state_q     <= ST_IDLE;
         prev_cnt_q  <= '0;
         prev_mode_q <= 1'b0;
         wrap_up_q   <= 1'b0;
         wrap_dn_q   <= 1'b0;
         step_err_q  <= 1'b0;
         fault_q     <= 1'b0;
         wrap_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         prev_cnt_q  <= prev_cnt_d;
         prev_mode_q <= prev_mode_d;
         wrap_up_q   <= wrap_up_d;
         wrap_dn_q   <= wrap_dn_d;
         step_err_q  <= step_err_d;
         fault_q     <= fault_d;
         wrap_cnt_q  <= wrap_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      prev_cnt_d  = prev_cnt_q;
      prev_mode_d = prev_mode_q;
      wrap_up_d   = 1'b0;
      wrap_dn_d   = 1'b0;
      step_err_d  = 1'b0;
      fault_d     = fault_q;
      wrap_cnt_d  = wrap_cnt_q;

      if (bus.en) begin
         prev_cnt_d  = bus.count_in;
         prev_mode_d = bus.mode;
         case (state_q)
            ST_IDLE: state_d = ST_TRACK;
            ST_TRACK: begin
               // Direction comes from the mode sampled with prev_cnt: the counter
               // applies a new mode one edge after it is presented.
               if (bus.count_in == prev_cnt_q) begin
                  state_d = ST_TRACK;
               end else if (prev_mode_q && (bus.count_in == exp_up)) begin
                  if (prev_cnt_q == CNT_MAX) begin
                     wrap_up_d  = 1'b1;
                     wrap_cnt_d = wrap_cnt_inc;
                  end
               end else if (!prev_mode_q && (bus.count_in == exp_dn)) begin
                  if (prev_cnt_q == '0) begin
                     wrap_dn_d  = 1'b1;
                     wrap_cnt_d = wrap_cnt_inc;
                  end
               end else begin
                  step_err_d = 1'b1;
                  fault_d    = 1'b1;
                  state_d    = ST_FAULT;
               end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   assign bus.wrap_up  = wrap_up_q;
   assign bus.wrap_dn  = wrap_dn_q;
   assign bus.step_err = step_err_q;
   assign bus.fault    = fault_q;
   assign bus.wrap_cnt = wrap_cnt_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_updown_count_monitor.sv
// Directed bench for updown_count_monitor: default instance plus a WRAPS_W=2
// instance for the saturation case.
module tb_updown_count_monitor;

   logic clk = 1'b0;
   logic reset_a;
   logic reset_b;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   updown_count_monitor_if #(.WIDTH(3), .WRAPS_W(8)) ifa ();
   updown_count_monitor_if #(.WIDTH(3), .WRAPS_W(2)) ifb ();

   updown_count_monitor #(.WIDTH(3), .WRAPS_W(8)) dut_a (
      .clk   (clk),
      .reset (reset_a),
      .bus   (ifa.slave)
   );

   updown_count_monitor #(.WIDTH(3), .WRAPS_W(2)) dut_b (
      .clk   (clk),
      .reset (reset_b),
      .bus   (ifb.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive dut_a for one cycle; outputs are then valid for that sample
   task automatic step(input logic e, input logic c, input logic m, input logic [2:0] v);
      ifa.en       = e;
      ifa.clr      = c;
      ifa.mode     = m;
      ifa.count_in = v;
      tick();
   endtask

   task automatic chk_a(input string tag, input logic [1:0] st, input logic wu, input logic wd,
                        input logic se, input logic f, input logic [7:0] wc);
      chk({tag, ".state"},    32'(ifa.state),    32'(st));
      chk({tag, ".wrap_up"},  32'(ifa.wrap_up),  32'(wu));
      chk({tag, ".wrap_dn"},  32'(ifa.wrap_dn),  32'(wd));
      chk({tag, ".step_err"}, 32'(ifa.step_err), 32'(se));
      chk({tag, ".fault"},    32'(ifa.fault),    32'(f));
      chk({tag, ".wrap_cnt"}, 32'(ifa.wrap_cnt), 32'(wc));
   endtask

   initial begin
      reset_a = 1'b0;
      reset_b = 1'b0;
      ifa.en = 1'b1; ifa.clr = 1'b0; ifa.mode = 1'b1; ifa.count_in = 3'd5;
      ifb.en = 1'b0; ifb.clr = 1'b0; ifb.mode = 1'b1; ifb.count_in = 3'd0;
      tick();
      tick();
      chk_a("reset", 2'd0, 0, 0, 0, 0, 8'd0);
      chk("reset_b.state", 32'(ifb.state), 32'd0);
      chk("reset_b.wrap_cnt", 32'(ifb.wrap_cnt), 32'd0);

      // up count with a wrap
      reset_a = 1'b1;
      step(1, 0, 1, 3'd0);
      chk_a("up_first", 2'd1, 0, 0, 0, 0, 8'd0);
      for (int v = 1; v <= 7; v++) begin
         step(1, 0, 1, 3'(v));
         chk("up_walk.wrap_up", 32'(ifa.wrap_up), 32'd0);
         chk("up_walk.fault", 32'(ifa.fault), 32'd0);
      end
      step(1, 0, 1, 3'd0);
      chk_a("up_wrap", 2'd1, 1, 0, 0, 0, 8'd1);
      step(1, 0, 1, 3'd1);
      chk_a("up_after_wrap", 2'd1, 0, 0, 0, 0, 8'd1);

      // turn around and count down through 0
      step(1, 0, 1, 3'd2);
      step(1, 0, 1, 3'd3);
      step(1, 0, 0, 3'd3);
      chk_a("mode_flip_hold", 2'd1, 0, 0, 0, 0, 8'd1);
      step(1, 0, 0, 3'd2);
      step(1, 0, 0, 3'd1);
      step(1, 0, 0, 3'd0);
      chk_a("dn_to_zero", 2'd1, 0, 0, 0, 0, 8'd1);
      step(1, 0, 0, 3'd7);
      chk_a("dn_wrap", 2'd1, 0, 1, 0, 0, 8'd2);
      step(1, 0, 0, 3'd6);
      chk_a("dn_after_wrap", 2'd1, 0, 0, 0, 0, 8'd2);

      // back up, one more wrap, then a skip to fault
      step(1, 0, 1, 3'd6);
      step(1, 0, 1, 3'd7);
      step(1, 0, 1, 3'd0);
      chk_a("up_wrap2", 2'd1, 1, 0, 0, 0, 8'd3);
      step(1, 0, 1, 3'd1);
      step(1, 0, 1, 3'd2);
      step(1, 0, 1, 3'd3);
      step(1, 0, 1, 3'd5);
      chk_a("skip_err", 2'd2, 0, 0, 1, 1, 8'd3);
      step(1, 0, 1, 3'd6);
      chk_a("fault_sticky", 2'd2, 0, 0, 0, 1, 8'd3);
      step(1, 0, 1, 3'd7);
      step(1, 0, 1, 3'd0);
      chk_a("fault_no_wrap", 2'd2, 0, 0, 0, 1, 8'd3);

      // soft clear out of FAULT
      step(1, 1, 1, 3'd4);
      chk_a("clr", 2'd0, 0, 0, 0, 0, 8'd0);

      // direction change one edge late is legal
      step(1, 0, 1, 3'd4);
      chk_a("re_track", 2'd1, 0, 0, 0, 0, 8'd0);
      step(1, 0, 1, 3'd5);
      step(1, 0, 0, 3'd6);
      chk_a("late_dir_up", 2'd1, 0, 0, 0, 0, 8'd0);
      step(1, 0, 0, 3'd5);
      step(1, 0, 0, 3'd4);
      chk_a("late_dir_dn", 2'd1, 0, 0, 0, 0, 8'd0);

      // reverse step while prev_mode is up is an error
      step(1, 0, 1, 3'd4);
      step(1, 0, 1, 3'd5);
      step(1, 0, 1, 3'd4);
      chk_a("wrong_dir", 2'd2, 0, 0, 1, 1, 8'd0);

      // reset beats en and clr
      reset_a = 1'b0;
      step(1, 0, 1, 3'd6);
      chk_a("reset_wins", 2'd0, 0, 0, 0, 0, 8'd0);
      reset_a = 1'b1;

      // enable gating
      step(1, 0, 1, 3'd6);
      step(1, 0, 1, 3'd7);
      step(1, 0, 1, 3'd0);
      chk_a("pre_hold_wrap", 2'd1, 1, 0, 0, 0, 8'd1);
      step(0, 0, 0, 3'd3);
      chk_a("en_low_1", 2'd1, 0, 0, 0, 0, 8'd1);
      step(0, 0, 1, 3'd6);
      step(0, 0, 0, 3'd2);
      step(0, 0, 1, 3'd7);
      step(0, 0, 0, 3'd5);
      chk_a("en_low_5", 2'd1, 0, 0, 0, 0, 8'd1);
      step(1, 0, 1, 3'd1);
      chk_a("en_resume", 2'd1, 0, 0, 0, 0, 8'd1);

      // saturation on the narrow wrap counter
      ifa.en = 1'b0;
      reset_b = 1'b1;
      ifb.en = 1'b1; ifb.mode = 1'b1; ifb.count_in = 3'd0;
      tick();
      chk("sat.state", 32'(ifb.state), 32'd1);
      for (int w = 1; w <= 5; w++) begin
         for (int v = 1; v <= 7; v++) begin
            ifb.count_in = 3'(v);
            tick();
         end
         ifb.count_in = 3'd0;
         tick();
         chk($sformatf("sat.wrap_up%0d", w), 32'(ifb.wrap_up), 32'd1);
         chk($sformatf("sat.wrap_cnt%0d", w), 32'(ifb.wrap_cnt), (w > 3) ? 32'd3 : 32'(w));
      end
      chk("sat.fault", 32'(ifb.fault), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/updown_count_monitor.md
Name: updown_count_monitor

Overview:
- Downstream consumer of the 3-bit up/down counter.
- Samples the counter value and mode every enabled cycle and checks that each transition is a legal step: hold, +1 or -1 modulo 2^WIDTH.
- Reports wrap events and keeps a saturating wrap count.
- Latches a sticky fault on any illegal transition.
- Used as an in-system checker and as the scoreboard stage in counter benches.

Parameters:
- WIDTH, 3, width of the monitored count bus.
- WRAPS_W, 8, width of the saturating wrap counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- en  input  1  sample enable; when low, all state and outputs hold and pulses deassert.
- clr  input  1  synchronous soft clear; same effect as reset, lower priority than reset.
- mode  input  1  counter direction as driven to the counter: 1 = up, 0 = down.
- count_in  input  WIDTH  counter output being monitored.
- wrap_up  output  1  one-cycle pulse: legal up-step from all-ones to 0.
- wrap_dn  output  1  one-cycle pulse: legal down-step from 0 to all-ones.
- step_err  output  1  one-cycle pulse on the transition that caused a fault.
- fault  output  1  sticky fault flag.
- wrap_cnt  output  WRAPS_W  total wraps in both directions, saturating at all-ones.
- state  output  2  FSM state: 0 IDLE, 1 TRACK, 2 FAULT.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values:
  - When reset==0 at a clk edge: state=IDLE.
  - wrap_up=0, wrap_dn=0, step_err=0, fault=0, wrap_cnt=0.
  - Internal prev_cnt=0, prev_mode=0.
- clr==1 (with reset high) has the identical effect. reset overrides clr and en; clr overrides en.
- All outputs are registered. A result appears the cycle after the sample that caused it (1-cycle latency).
- en==0: no state change; wrap_up, wrap_dn and step_err are 0 on the next cycle; fault and wrap_cnt hold.
- Direction rule: the expected value uses prev_mode, the mode sampled together with prev_cnt. The counter applies mode at the edge after it is presented.
- IDLE, en==1: capture prev_cnt=count_in and prev_mode=mode; go to TRACK. No check and no pulses.
- TRACK, en==1: exp_up=prev_cnt+1 and exp_dn=prev_cnt-1, both truncated to WIDTH bits.
  - count_in==prev_cnt: legal hold; no pulse.
  - prev_mode==1 and count_in==exp_up: legal. If prev_cnt==all-ones, pulse wrap_up and increment wrap_cnt (saturating).
  - prev_mode==0 and count_in==exp_dn: legal. If prev_cnt==0, pulse wrap_dn and increment wrap_cnt (saturating).
  - Any other value, including a correct-magnitude step in the wrong direction: pulse step_err, set fault=1, go to FAULT.
  - On every enabled cycle, update prev_cnt=count_in and prev_mode=mode.
- FAULT: no further checking, pulses or wrap counting. prev_cnt and prev_mode still track count_in and mode. Exit only via reset or clr, both to IDLE.
- wrap_cnt saturates at 2^WRAPS_W-1; further wraps still pulse wrap_up/wrap_dn but do not change wrap_cnt.
- Mode change mid-stream: the first step after the change is checked against the old prev_mode. A hold on that cycle is legal. This matches a counter that changes direction one edge after mode toggles.
- Counter reset mid-stream, count_in jumping to 0:
  - Legal only if it equals the hold, +1 or -1 expectation.
  - Otherwise it is a fault. Benches must pulse clr alongside the counter reset.
- A wrap and an error cannot occur on the same cycle; at most one of wrap_up, wrap_dn, step_err is high.

Test Plan:
- Reset low 2 cycles, then en=1, mode=1, count_in 0,1,...,7,0,1 -> state TRACK; wrap_up=1 exactly one cycle after count_in returns to 0; wrap_cnt=1; fault=0.
- mode=0, count_in 3,2,1,0,7,6 -> wrap_dn single pulse after 7 is sampled; wrap_cnt increments by 1; no step_err.
- mode=1, count_in 2,3,5 -> step_err pulses once the cycle after 5 is sampled; fault=1; state=FAULT; later wraps give no pulses and wrap_cnt is unchanged.
- Up count 4,5; mode toggles to 0 with the counter showing 6, then 5,4 -> all legal; fault stays 0. Same sequence with 4,5,4 while prev_mode==1 -> step_err.
- WRAPS_W=2, 5 up-wraps -> wrap_cnt=3 (saturated); fifth wrap still pulses wrap_up.
- In FAULT: clr=1 one cycle -> state=IDLE, fault=0, wrap_cnt=0. Then reset=0 asserted together with en=1 and clr=0 -> reset wins and all outputs are 0 next cycle. en=0 for 5 cycles with count_in changing -> no state or output change.
